// File: rtl/regfile_pkg.sv
// Shared constants for the decode-stage register file and its scoreboard.
// Holds register-name constants, the link register index and counter width.
package regfile_pkg;

  localparam int ZERO_REG         = 0;
  localparam int LINK_REG_DEFAULT = 31;
  localparam int CNT_W_DEFAULT    = 2;

  typedef enum logic [4:0] {
    REG_ZERO, REG_AT, REG_V0, REG_V1,
    REG_A0,   REG_A1, REG_A2, REG_A3,
    REG_T0,   REG_T1, REG_T2, REG_T3,
    REG_T4,   REG_T5, REG_T6, REG_T7,
    REG_S0,   REG_S1, REG_S2, REG_S3,
    REG_S4,   REG_S5, REG_S6, REG_S7,
    REG_T8,   REG_T9, REG_K0, REG_K1,
    REG_GP,   REG_SP, REG_FP, REG_RA
  } mips_reg_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write counters, hazard stall and underflow flag.
// Ports: writeback retire, issue request, Stall, Busy, ScoreErr.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int AW    = 5,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              WriteEnb,
  input  logic [AW-1:0]     WriteReg,
  input  logic              IssueValid,
  input  logic [AW-1:0]     IssueSrcA,
  input  logic              IssueSrcAEn,
  input  logic [AW-1:0]     IssueSrcB,
  input  logic              IssueSrcBEn,
  input  logic [AW-1:0]     IssueDst,
  input  logic              IssueDstEn,
  output logic              Stall,
  output logic [2**AW-1:0]  Busy,
  output logic              ScoreErr
);

  localparam int NREG = 2**AW;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [CNT_W-1:0] cnt [NREG];
  logic             retire;
  logic             accept;
  logic             haz_a;
  logic             haz_b;
  logic             haz_d;
  logic [NREG-1:0]  acc_v;
  logic [NREG-1:0]  ret_v;

  assign retire = WriteEnb && (WriteReg != '0);

  // A producer retiring this cycle is satisfied through the read bypass.
  assign haz_a = IssueSrcAEn && (IssueSrcA != '0) &&
    (cnt[IssueSrcA] !=
     CNT_W'(retire && (WriteReg == IssueSrcA)));
  assign haz_b = IssueSrcBEn && (IssueSrcB != '0) &&
    (cnt[IssueSrcB] !=
     CNT_W'(retire && (WriteReg == IssueSrcB)));
  assign haz_d = IssueDstEn && (IssueDst != '0) &&
    (cnt[IssueDst] == CMAX) &&
    !(retire && (WriteReg == IssueDst));

  assign Stall  = IssueValid && (haz_a || haz_b || haz_d);
  assign accept = IssueValid && !Stall &&
                  IssueDstEn && (IssueDst != '0);

  always_comb begin
    acc_v = '0;
    ret_v = '0;
    if (accept) acc_v[IssueDst] = 1'b1;
    if (retire) ret_v[WriteReg] = 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      ScoreErr <= 1'b0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (acc_v[r] && !ret_v[r]) begin
          cnt[r] <= cnt[r] + 1'b1;
        end else if (ret_v[r] && !acc_v[r]) begin
          if (cnt[r] != '0) cnt[r] <= cnt[r] - 1'b1;
          else              ScoreErr <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    Busy = '0;
    for (int r = 0; r < NREG; r++) Busy[r] = (cnt[r] != '0);
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Decode-stage register file: bypassed reads, writeback and link ports.
// Ports: read addr/data, write/link ports, issue/stall scoreboard view.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NUM_READ = 2,
  parameter int LINK_REG = LINK_REG_DEFAULT,
  parameter int CNT_W    = CNT_W_DEFAULT
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic [NUM_READ*AW-1:0] ReadAddr,
  output logic [NUM_READ*DW-1:0] ReadData,
  input  logic                   WriteEnb,
  input  logic [AW-1:0]          WriteReg,
  input  logic [DW-1:0]          WriteData,
  input  logic                   WriteCancel,
  input  logic                   LinkEnb,
  input  logic [DW-1:0]          LinkData,
  input  logic                   IssueValid,
  input  logic [AW-1:0]          IssueSrcA,
  input  logic [AW-1:0]          IssueSrcB,
  input  logic                   IssueSrcAEn,
  input  logic                   IssueSrcBEn,
  input  logic [AW-1:0]          IssueDst,
  input  logic                   IssueDstEn,
  output logic                   Stall,
  output logic [2**AW-1:0]       Busy,
  output logic                   ScoreErr
);

  localparam int NREG = 2**AW;
  localparam logic [AW-1:0] LINK_A = AW'(LINK_REG);

  logic [DW-1:0] mem [NREG];
  logic          wr_eff;
  logic          lk_eff;

  assign wr_eff = WriteEnb && !WriteCancel &&
                  (WriteReg != '0);
  assign lk_eff = LinkEnb && (LINK_A != '0);

  // Link write is issued last so it wins a same-cycle clash.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int r = 0; r < NREG; r++) mem[r] <= '0;
    end else begin
      if (wr_eff) mem[WriteReg] <= WriteData;
      if (lk_eff) mem[LINK_A]   <= LinkData;
    end
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [AW-1:0] addr;
    logic [DW-1:0] dout;
    assign addr = ReadAddr[i*AW +: AW];
    always_comb begin
      if (addr == '0)
        dout = '0;
      else if (LinkEnb && addr == LINK_A)
        dout = LinkData;
      else if (wr_eff && addr == WriteReg)
        dout = WriteData;
      else
        dout = mem[addr];
    end
    assign ReadData[i*DW +: DW] = dout;
  end

  rf_scoreboard #(
    .AW    (AW),
    .CNT_W (CNT_W)
  ) u_sb (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .WriteEnb    (WriteEnb),
    .WriteReg    (WriteReg),
    .IssueValid  (IssueValid),
    .IssueSrcA   (IssueSrcA),
    .IssueSrcAEn (IssueSrcAEn),
    .IssueSrcB   (IssueSrcB),
    .IssueSrcBEn (IssueSrcBEn),
    .IssueDst    (IssueDst),
    .IssueDstEn  (IssueDstEn),
    .Stall       (Stall),
    .Busy        (Busy),
    .ScoreErr    (ScoreErr)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: directed vectors queue
// expected values; a negedge monitor pops and compares them.
module tb_regfile_scoreboard;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic [AW-1:0] ra0, ra1;
  logic [2*AW-1:0] ReadAddr;
  logic [2*DW-1:0] ReadData;
  logic          WriteEnb, WriteCancel, LinkEnb;
  logic [AW-1:0] WriteReg;
  logic [DW-1:0] WriteData, LinkData;
  logic          IssueValid, IssueSrcAEn, IssueSrcBEn, IssueDstEn;
  logic [AW-1:0] IssueSrcA, IssueSrcB, IssueDst;
  logic          Stall, ScoreErr;
  logic [31:0]   Busy;

  assign ReadAddr = {ra1, ra0};

  regfile_scoreboard dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .ReadAddr    (ReadAddr),
    .ReadData    (ReadData),
    .WriteEnb    (WriteEnb),
    .WriteReg    (WriteReg),
    .WriteData   (WriteData),
    .WriteCancel (WriteCancel),
    .LinkEnb     (LinkEnb),
    .LinkData    (LinkData),
    .IssueValid  (IssueValid),
    .IssueSrcA   (IssueSrcA),
    .IssueSrcB   (IssueSrcB),
    .IssueSrcAEn (IssueSrcAEn),
    .IssueSrcBEn (IssueSrcBEn),
    .IssueDst    (IssueDst),
    .IssueDstEn  (IssueDstEn),
    .Stall       (Stall),
    .Busy        (Busy),
    .ScoreErr    (ScoreErr)
  );

  always #5 Clk = ~Clk;

  typedef enum int {K_RD0, K_RD1, K_STALL, K_BBIT, K_BALL, K_ERR} kind_e;
  typedef struct {
    kind_e       kind;
    int          idx;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic expect_v(input kind_e k, input int idx,
                          input logic [31:0] v, input string nm);
    exp_t e;
    e.kind = k; e.idx = idx; e.exp = v; e.name = nm;
    exp_q.push_back(e);
  endtask

  always @(negedge Clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [31:0] got;
      e = exp_q.pop_front();
      case (e.kind)
        K_RD0:   got = ReadData[DW-1:0];
        K_RD1:   got = ReadData[2*DW-1:DW];
        K_STALL: got = {31'd0, Stall};
        K_BBIT:  got = {31'd0, Busy[e.idx]};
        K_BALL:  got = Busy;
        default: got = {31'd0, ScoreErr};
      endcase
      n_checks++;
      if (got !== e.exp) begin
        n_err++;
        $display("FAIL %s: got %h want %h", e.name, got, e.exp);
      end
    end
  end

  task automatic idle();
    ra0 = '0; ra1 = '0;
    WriteEnb = 0; WriteCancel = 0; WriteReg = '0; WriteData = '0;
    LinkEnb = 0; LinkData = '0;
    IssueValid = 0; IssueSrcAEn = 0; IssueSrcBEn = 0; IssueDstEn = 0;
    IssueSrcA = '0; IssueSrcB = '0; IssueDst = '0;
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
    idle();
  endtask

  task automatic wr(input int r, input logic [31:0] d);
    WriteEnb = 1; WriteReg = AW'(r); WriteData = d;
  endtask

  task automatic iss_dst(input int r);
    IssueValid = 1; IssueDstEn = 1; IssueDst = AW'(r);
  endtask

  task automatic pulse_reset();
    Reset_n = 0;
    @(negedge Clk);
    #1;
    Reset_n = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    Reset_n = 0;
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1;

    // reset state
    cyc(); ra0 = 8;
    expect_v(K_RD0, 0, 0, "rst_rd_r8");
    expect_v(K_BALL, 0, 0, "rst_busy");
    expect_v(K_ERR, 0, 0, "rst_err");
    expect_v(K_STALL, 0, 0, "rst_stall");

    // bypass and cancel
    cyc(); wr(9, 32'h1234); ra0 = 9;
    expect_v(K_RD0, 0, 32'h1234, "byp_r9");
    cyc(); wr(9, 32'hABCD); WriteCancel = 1; ra0 = 9;
    expect_v(K_RD0, 0, 32'h1234, "cancel_byp");
    cyc(); ra0 = 9;
    expect_v(K_RD0, 0, 32'h1234, "cancel_kept");

    // link priority, r0 drop
    cyc(); LinkEnb = 1; LinkData = 32'h400; wr(31, 32'h99);
    ra0 = 31; ra1 = 31;
    expect_v(K_RD0, 0, 32'h400, "link_byp0");
    expect_v(K_RD1, 0, 32'h400, "link_byp1");
    cyc(); ra1 = 31;
    expect_v(K_RD1, 0, 32'h400, "link_stored");
    cyc(); wr(0, 32'h77); ra0 = 0;
    expect_v(K_RD0, 0, 0, "r0_byp");
    cyc(); ra0 = 0;
    expect_v(K_RD0, 0, 0, "r0_stored");
    expect_v(K_ERR, 0, 1, "err_after_retires");

    // reset mid-run
    cyc(); wr(8, 32'hDEADBEEF); ra0 = 8;
    expect_v(K_RD0, 0, 32'hDEADBEEF, "r8_byp");
    cyc(); ra0 = 8; ra1 = 9;
    expect_v(K_RD0, 0, 32'hDEADBEEF, "r8_stored");
    cyc(); ra0 = 8; ra1 = 9;
    expect_v(K_RD0, 0, 0, "midrst_r8");
    expect_v(K_RD1, 0, 0, "midrst_r9");
    expect_v(K_BALL, 0, 0, "midrst_busy");
    expect_v(K_ERR, 0, 0, "midrst_err");
    pulse_reset();

    // RAW hazard
    cyc(); iss_dst(10);
    expect_v(K_STALL, 0, 0, "raw_accept");
    cyc(); IssueValid = 1; IssueSrcBEn = 1; IssueSrcB = 10;
    expect_v(K_STALL, 0, 1, "raw_srcb");
    expect_v(K_BBIT, 10, 1, "raw_busy10");
    cyc(); IssueValid = 1; IssueSrcAEn = 1; IssueSrcA = 10;
    expect_v(K_STALL, 0, 1, "raw_srca");
    cyc(); IssueValid = 1; IssueSrcAEn = 1; IssueSrcA = 10;
    wr(10, 32'h5A5A); ra0 = 10;
    expect_v(K_STALL, 0, 0, "raw_retire");
    expect_v(K_RD0, 0, 32'h5A5A, "raw_byp");
    cyc(); ra0 = 10;
    expect_v(K_BBIT, 10, 0, "raw_busy_clr");
    expect_v(K_RD0, 0, 32'h5A5A, "raw_stored");

    // saturation
    for (int k = 0; k < 3; k++) begin
      cyc(); iss_dst(5);
      expect_v(K_STALL, 0, 0, $sformatf("sat_acc%0d", k));
    end
    cyc(); iss_dst(5);
    expect_v(K_STALL, 0, 1, "sat_full");
    expect_v(K_BBIT, 5, 1, "sat_busy5");
    cyc(); iss_dst(5); wr(5, 32'h1);
    expect_v(K_STALL, 0, 0, "sat_retire_acc");
    cyc(); iss_dst(5);
    expect_v(K_STALL, 0, 1, "sat_still_full");

    // r0 retire harmless, then underflow
    cyc(); wr(0, 32'h3);
    cyc();
    expect_v(K_ERR, 0, 0, "r0_retire_noerr");
    cyc(); wr(12, 32'h3);
    cyc();
    expect_v(K_ERR, 0, 1, "uflow_err");
    expect_v(K_BBIT, 12, 0, "uflow_cnt0");
    cyc(); cyc();
    expect_v(K_ERR, 0, 1, "uflow_sticky");

    @(negedge Clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the decode-stage register file.
- Provides NUM_READ combinational read ports with same-cycle write-through bypass, a main writeback port and a dedicated link port (jal return address), and reset-cleared storage; the register file is not loaded from a file.
- Adds a per-register pending-write scoreboard. Decode uses it to raise a stall when a source or destination register still has an in-flight producer.
- Sits in the decode stage, fed by the control unit (issue) and by the MEM/WB pipeline register (writeback).

Parameters:
- DW, 32, data width.
- AW, 5, register address width; 2**AW registers.
- NUM_READ, 2, number of read ports (1..4).
- LINK_REG, 31, register written by the link port.
- CNT_W, 2, width of each pending-write counter; max in-flight writes per register = 2**CNT_W-1.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Reset_n  in  1  asynchronous active-low reset.
- ReadAddr  in  NUM_READ*AW  packed read addresses; port i = [i*AW +: AW].
- ReadData  out  NUM_READ*DW  packed read data; combinational.
- WriteEnb  in  1  writeback valid.
- WriteReg  in  AW  writeback destination.
- WriteData  in  DW  writeback data.
- WriteCancel  in  1  suppress data write (ALU overflow); the scoreboard still retires the entry.
- LinkEnb  in  1  write LinkData to LINK_REG.
- LinkData  in  DW  return address (caller supplies PC+4).
- IssueValid  in  1  decode presents an instruction.
- IssueSrcA, IssueSrcB  in  AW  source registers.
- IssueSrcAEn, IssueSrcBEn  in  1  the corresponding source is used.
- IssueDst  in  AW  destination register.
- IssueDstEn  in  1  the instruction writes IssueDst.
- Stall  out  1  combinational hazard; the issue is not accepted this cycle.
- Busy  out  2**AW  per-register "count != 0" vector.
- ScoreErr  out  1  sticky; set on a retire to a register whose count is 0.

Behaviour:
- Reset (async, Reset_n=0):
  - all registers, all counters and ScoreErr clear to 0.
  - ReadData then returns 0 (except active bypass); Busy=0; Stall=0.
  - Effect is immediate, mid-operation included; first update on the first posedge after deassertion.
- Register 0:
  - reads always 0; writes to it are dropped.
  - its counter never increments; a retire to it does not set ScoreErr.
- Data write: the effective write fires on posedge when WriteEnb & !WriteCancel & WriteReg!=0.
- Link write: fires on posedge when LinkEnb. Same-cycle effective write to LINK_REG from both ports: the link port wins.
- Writes to LINK_REG from the main port are legal.
- Read, per port i, priority order:
  1. addr==0 -> 0
  2. LinkEnb & addr==LINK_REG -> LinkData
  3. effective write & addr==WriteReg -> WriteData
  4. otherwise -> stored value
- Read latency is 0 cycles; bypass replaces negedge writing.
- Retire: WriteEnb & WriteReg!=0, independent of WriteCancel. The link port does not touch the scoreboard.
- Accept: IssueValid & !Stall & IssueDstEn & IssueDst!=0.
- Counter update per register r on posedge:
  - accept only -> +1.
  - retire only -> -1 if count>0; if count==0, set ScoreErr and leave the counter at 0.
  - accept and retire same cycle -> unchanged.
- Src hazard (src s): sEn & s!=0 & (count[s] - (retire & WriteReg==s)) != 0. A retiring producer is therefore treated as satisfied via bypass.
- Dst hazard: IssueDstEn & IssueDst!=0 & count[IssueDst]==max & !(retire & WriteReg==IssueDst).
- Stall = IssueValid & (srcA hazard | srcB hazard | dst hazard).
- Busy[r] = (count[r] != 0), registered view of the counters.

Decomposition:
- Shared package regfile_pkg holds:
  - ZERO_REG=0 and LINK_REG_DEFAULT=31;
  - MIPS register-name constants (zero..ra);
  - the default CNT_W.
- Sub-module rf_scoreboard owns the counters, ScoreErr, Busy and Stall logic.
- The top level holds storage, the write ports and the bypass read mux.

Test Plan:
- Reset mid-run:
  - write 0xDEADBEEF to r8, then pulse Reset_n low between edges.
  - -> read r8 = 0 immediately; Busy = 0; ScoreErr = 0.
- Bypass:
  - WriteEnb, WriteReg=9, WriteData=0x1234, ReadAddr0=9.
  - -> ReadData0 = 0x1234 in the same cycle.
  - With WriteCancel=1 instead -> old value is read and r9 is unchanged after the edge.
- Link priority:
  - LinkEnb, LinkData=0x400, plus WriteEnb to r31 with 0x99.
  - -> read r31 = 0x400 before and after the edge.
  - Separately, a write to r0 -> r0 reads 0.
- Scoreboard RAW:
  - accept dst r10, then in the next cycle issue srcA=r10 -> Stall = 1.
  - In the cycle WriteEnb, WriteReg=10 -> Stall = 0, ReadData = WriteData, Busy[10] clears after the edge.
- Counter saturation:
  - CNT_W=2, accept three writes to r5 without retire; a fourth issue to dst r5 -> Stall = 1.
  - Same cycle with a retire of r5 -> accepted, count stays 3.
- Underflow: retire r12 with count 0 -> ScoreErr = 1 and stays 1 until reset; the counter remains 0.
